stage_mem_lsu: RTL and testbench
================================

Name: stage_mem_lsu

Overview:
Next-generation Memory Access pipeline stage, parametrised in data width and memory timeout. It drives an external variable-latency data memory through a req/ack handshake and stalls the pipeline while an access is outstanding. It supports byte, halfword and word (and dword at 64 bits) loads and stores, with byte enables, load sign/zero extension, misalignment trapping and store-data forwarding. It sits between the EX/MEM register and the WR stage and owns the MEM/WR pipeline register.

Parameters:
DATA_W, 32, datapath and memory word width; 32 or 64 only.
ADDR_W, 32, byte address width.
REG_AW, 5, register index width.
MEM_TIMEOUT, 15, maximum wait cycles for Mem_Ack before a bus error; range 1..255.

Ports:
- Clk in 1: clock, rising edge.
- Rst_n in 1: reset; synchronous, active-low.
- MEMin_Valid in 1: an instruction is present.
- MEMin_ALUout in ADDR_W: effective address / ALU result.
- MEMin_busB in DATA_W: store data.
- MEMin_Rt in REG_AW: store source register.
- MEMin_Rw in REG_AW: destination register.
- MEMin_RegWr, MEMin_MemtoReg, MEMin_MemRd, MEMin_MemWr, MEMin_Branch, MEMin_Jump, MEMin_Zero, MEMin_Overflow in 1 each: control/status bits from EX/MEM.
- MEMin_Size in 2: access size; 0 = byte, 1 = half, 2 = word, 3 = dword.
- MEMin_SignExt in 1: sign-extend loads.
- MEMin_Btarg, MEMin_Jtarg in ADDR_W: branch and jump targets.
- WR_RegDin in DATA_W; WR_Rw in REG_AW; WR_RegWr in 1: write-back forwarding source.
- Mem_Req out 1; Mem_We out 1; Mem_Addr out ADDR_W; Mem_WData out DATA_W; Mem_BE out DATA_W/8.
- Mem_Ack in 1; Mem_RData in DATA_W.
- Stall out 1: freezes IF/ID/EX and EX/MEM.
- PCSrc out 1; Btarg_or_Jtarg out ADDR_W.
- WRin_Valid, WRin_RegWr, WRin_MemtoReg, WRin_Overflow, WRin_AddrExc, WRin_BusErr out 1 each.
- WRin_Dout, WRin_ALUout out DATA_W; WRin_Rw out REG_AW: registered MEM/WR outputs.

Behaviour:
- OFF = log2(DATA_W/8) low address bits.
- Access = MEMin_Valid & (MEMin_MemRd | MEMin_MemWr).
- Misaligned when any of these hold:
  - size 1 and addr[0] = 1;
  - size 2 and addr[1:0] ≠ 0;
  - size 3 and addr[2:0] ≠ 0;
  - size 3 when DATA_W = 32.
- Reset (Rst_n = 0 at a clock edge): state IDLE, timeout counter 0. Mem_Req, Mem_We, Mem_Addr, Mem_WData and Mem_BE are 0. All WRin_* outputs are 0. Reset mid-access abandons the request; Mem_Req is low the cycle after the reset edge.
- FSM, state IDLE:
  - If Access & !misaligned: register Mem_Addr = address with the OFF bits cleared, Mem_We = MemWr, Mem_BE and Mem_WData. Set Mem_Req <= 1 and go to WAIT. Stall = 1 this cycle.
  - Otherwise Stall = 0.
- FSM, state WAIT: Stall = 1; Mem_Req stays held and all Mem_* are stable.
  - On Mem_Ack: Mem_Req <= 0; latch the extracted load data; go to DONE.
  - Otherwise the counter increments. When the counter reaches MEM_TIMEOUT-1 without an ack: Mem_Req <= 0, set the bus-error flag, go to DONE.
- FSM, state DONE: Stall = 0; the MEM/WR register loads; go to IDLE next cycle and clear the counter. The EX/MEM inputs are held stable by the stall until DONE.
- Non-memory instruction or misaligned access: no request is issued, Stall = 0, and the instruction passes in one cycle.
- Store lanes:
  - Mem_WData = source data replicated per size: byte ×(DATA_W/8), half ×(DATA_W/16), and so on.
  - Mem_BE = size mask (1, 3, 0xF, 0xFF) shifted left by the offset.
- Store-data source: WR_RegDin if WR_RegWr & WR_Rw == MEMin_Rt & MEMin_Rt ≠ 0; otherwise MEMin_busB. Sampled in the IDLE launch cycle.
- Load data:
  - Take Mem_RData shifted right by offset×8 and masked to size.
  - Extend with the MSB of that size if MEMin_SignExt, else with zeros.
  - On a bus error, load data = 0.
- MEM/WR register update on every non-reset edge:
  - If Stall = 1: bubble; WRin_Valid and WRin_RegWr <= 0, other fields keep their values.
  - Else: WRin_Valid = MEMin_Valid.
  - WRin_RegWr = RegWr & Valid & !misaligned & !buserr.
  - WRin_AddrExc = Valid & Access & misaligned.
  - WRin_BusErr = bus-error flag.
  - Rw, ALUout, MemtoReg and Overflow pass through.
  - WRin_Dout = latched load data.
- PCSrc = MEMin_Valid & !Stall & (Jump | Branch & Zero). This asserts exactly once per instruction.
- Btarg_or_Jtarg = Jump ? Jtarg : Btarg.
- A simultaneous Mem_Ack and timeout expiry in the same cycle counts as an ack; no bus error is raised.

Test Plan:
- Load word, ack after 3 cycles: addr 0x100, MemRd, size 2, Mem_RData 0xDEADBEEF → Stall is high for 4 cycles, Mem_BE = 0xF, then WRin_Dout = 0xDEADBEEF and WRin_RegWr = 1.
- Store byte at addr 0x203: busB = 0x000000A5 → Mem_We = 1, Mem_BE = 0x8, Mem_WData = 0xA5A5A5A5. Repeat with WR_Rw == Rt, WR_RegWr = 1, WR_RegDin = 0x3C → Mem_WData = 0x3C3C3C3C.
- Signed load half at addr 0x002: Mem_RData 0x8001_1234 → WRin_Dout = 0xFFFF8001. The same access with SignExt = 0 → 0x00008001.
- Misaligned load word at addr 0x101 → no Mem_Req, Stall = 0, WRin_AddrExc = 1, WRin_RegWr = 0.
- Never ack, MEM_TIMEOUT = 4 → Mem_Req drops after 4 WAIT cycles, WRin_BusErr = 1, WRin_Dout = 0. Rst_n low during WAIT → Mem_Req = 0 and all WRin_* = 0 next cycle.
- Branch with Zero = 1 behind a stalled load → PCSrc stays 0 until the DONE cycle, then pulses for exactly one cycle with Btarg_or_Jtarg = MEMin_Btarg.

Source files
------------

// File: rtl/stage_mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : stage_mem_lsu
//  Purpose  : Memory-access pipeline stage. Launches loads and stores to a
//             variable-latency data memory over a req/ack handshake. Stalls
//             the front of the pipeline while an access is outstanding.
//             Owns the MEM/WR pipeline register.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    Clk, Rst_n         clock (rising edge); synchronous active-low reset
//    MEMin_*            EX/MEM register contents (held stable while stalled)
//    WR_RegDin/Rw/RegWr write-back stage result, used to forward store data
//    Mem_Req/We/Addr/WData/BE
//                       registered request to the data memory
//    Mem_Ack/RData      memory response
//    Stall              freezes IF/ID/EX and the EX/MEM register
//    PCSrc, Btarg_or_Jtarg
//                       redirect request and its target
//    WRin_*             registered MEM/WR outputs
// ============================================================================
module stage_mem_lsu #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int REG_AW      = 5,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                MEMin_Valid,
    input  logic [ADDR_W-1:0]   MEMin_ALUout,
    input  logic [DATA_W-1:0]   MEMin_busB,
    input  logic [REG_AW-1:0]   MEMin_Rt,
    input  logic [REG_AW-1:0]   MEMin_Rw,
    input  logic                MEMin_RegWr,
    input  logic                MEMin_MemtoReg,
    input  logic                MEMin_MemRd,
    input  logic                MEMin_MemWr,
    input  logic                MEMin_Branch,
    input  logic                MEMin_Jump,
    input  logic                MEMin_Zero,
    input  logic                MEMin_Overflow,
    input  logic [1:0]          MEMin_Size,
    input  logic                MEMin_SignExt,
    input  logic [ADDR_W-1:0]   MEMin_Btarg,
    input  logic [ADDR_W-1:0]   MEMin_Jtarg,
    input  logic [DATA_W-1:0]   WR_RegDin,
    input  logic [REG_AW-1:0]   WR_Rw,
    input  logic                WR_RegWr,
    output logic                Mem_Req,
    output logic                Mem_We,
    output logic [ADDR_W-1:0]   Mem_Addr,
    output logic [DATA_W-1:0]   Mem_WData,
    output logic [DATA_W/8-1:0] Mem_BE,
    input  logic                Mem_Ack,
    input  logic [DATA_W-1:0]   Mem_RData,
    output logic                Stall,
    output logic                PCSrc,
    output logic [ADDR_W-1:0]   Btarg_or_Jtarg,
    output logic                WRin_Valid,
    output logic                WRin_RegWr,
    output logic                WRin_MemtoReg,
    output logic                WRin_Overflow,
    output logic                WRin_AddrExc,
    output logic                WRin_BusErr,
    output logic [DATA_W-1:0]   WRin_Dout,
    output logic [DATA_W-1:0]   WRin_ALUout,
    output logic [REG_AW-1:0]   WRin_Rw
);

    localparam int c_nbytes = DATA_W / 8;
    localparam int c_offw   = $clog2(c_nbytes);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_wait = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [7:0]          r_cnt;
    logic                r_buserr;
    logic [DATA_W-1:0]   r_load_data;

    logic                w_access;
    logic                w_size_bad;
    logic                w_misaligned;
    logic                w_launch;
    logic                w_timeout;
    logic                w_stall;
    logic [c_offw-1:0]   w_off;
    logic [DATA_W-1:0]   w_st_src;
    logic [DATA_W-1:0]   w_wdata;
    logic [7:0]          w_be_mask;
    logic [c_nbytes-1:0] w_be;
    logic [2:0]          w_lane_mask;
    logic [DATA_W-1:0]   w_shifted;
    logic [DATA_W-1:0]   w_size_mask;
    logic                w_sign;
    logic [DATA_W-1:0]   w_load_ext;

    // ------------------------------------------------------------------
    // Access decode and alignment
    // ------------------------------------------------------------------
    assign w_access = MEMin_Valid & (MEMin_MemRd | MEMin_MemWr);
    assign w_off    = MEMin_ALUout[c_offw-1:0];

    always_comb begin
        w_size_bad = 1'b0;
        case (MEMin_Size)
            2'd0:    w_size_bad = 1'b0;
            2'd1:    w_size_bad = MEMin_ALUout[0];
            2'd2:    w_size_bad = |MEMin_ALUout[1:0];
            default: w_size_bad = (DATA_W == 32) || (|MEMin_ALUout[2:0]);
        endcase
    end

    // Alignment only matters for real memory accesses; ALU results with
    // arbitrary low bits must not be flagged.
    assign w_misaligned = w_access & w_size_bad;
    assign w_launch     = w_access & ~w_misaligned;
    assign w_timeout    = (r_cnt == 8'(MEM_TIMEOUT - 1));

    // ------------------------------------------------------------------
    // Store lanes: forwarded source, replicated data, byte enables
    // ------------------------------------------------------------------
    assign w_st_src = (WR_RegWr && (WR_Rw == MEMin_Rt) && (MEMin_Rt != '0))
                      ? WR_RegDin : MEMin_busB;

    always_comb begin
        w_be_mask   = 8'h01;
        w_lane_mask = 3'd0;
        case (MEMin_Size)
            2'd0:    begin w_be_mask = 8'h01; w_lane_mask = 3'd0; end
            2'd1:    begin w_be_mask = 8'h03; w_lane_mask = 3'd1; end
            2'd2:    begin w_be_mask = 8'h0F; w_lane_mask = 3'd3; end
            default: begin w_be_mask = 8'hFF; w_lane_mask = 3'd7; end
        endcase
    end

    assign w_be = w_be_mask[c_nbytes-1:0] << w_off;

    // Each memory byte lane takes the source byte whose index is the lane
    // number modulo the access size, which replicates the operand.
    always_comb begin
        w_wdata = '0;
        for (int b = 0; b < c_nbytes; b++) begin
            w_wdata[b*8 +: 8] =
                w_st_src[{(3'(b) & w_lane_mask & 3'(c_nbytes - 1)), 3'b000} +: 8];
        end
    end

    // ------------------------------------------------------------------
    // Load extraction and extension
    // ------------------------------------------------------------------
    assign w_shifted = Mem_RData >> {w_off, 3'b000};

    always_comb begin
        w_size_mask = DATA_W'(8'hFF);
        w_sign      = w_shifted[7];
        case (MEMin_Size)
            2'd0:    begin w_size_mask = DATA_W'(8'hFF);         w_sign = w_shifted[7];        end
            2'd1:    begin w_size_mask = DATA_W'(16'hFFFF);      w_sign = w_shifted[15];       end
            2'd2:    begin w_size_mask = DATA_W'(32'hFFFF_FFFF); w_sign = w_shifted[31];       end
            default: begin w_size_mask = '1;                     w_sign = w_shifted[DATA_W-1]; end
        endcase
    end

    assign w_load_ext = (w_shifted & w_size_mask) |
                        ((MEMin_SignExt & w_sign) ? ~w_size_mask : '0);

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_launch) begin
                    w_stall     = 1'b1;
                    w_state_nxt = c_st_wait;
                end
            end
            c_st_wait: begin
                w_stall = 1'b1;
                if (Mem_Ack || w_timeout) begin
                    w_state_nxt = c_st_done;
                end
            end
            c_st_done: begin
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    assign Stall = w_stall;

    // Memory request, timeout counter and access result.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            Mem_Req     <= 1'b0;
            Mem_We      <= 1'b0;
            Mem_Addr    <= '0;
            Mem_WData   <= '0;
            Mem_BE      <= '0;
            r_cnt       <= '0;
            r_buserr    <= 1'b0;
            r_load_data <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_launch) begin
                        Mem_Req     <= 1'b1;
                        Mem_We      <= MEMin_MemWr;
                        Mem_Addr    <= {MEMin_ALUout[ADDR_W-1:c_offw], {c_offw{1'b0}}};
                        Mem_WData   <= w_wdata;
                        Mem_BE      <= w_be;
                        r_cnt       <= '0;
                        r_buserr    <= 1'b0;
                        r_load_data <= '0;
                    end
                end
                c_st_wait: begin
                    // An ack in the expiry cycle wins over the timeout.
                    if (Mem_Ack) begin
                        Mem_Req     <= 1'b0;
                        r_load_data <= w_load_ext;
                    end else if (w_timeout) begin
                        Mem_Req     <= 1'b0;
                        r_buserr    <= 1'b1;
                        r_load_data <= '0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    // DONE: result consumed by MEM/WR this edge; clear it so
                    // following pass-through instructions see a clean state.
                    r_cnt       <= '0;
                    r_buserr    <= 1'b0;
                    r_load_data <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // MEM/WR pipeline register
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            WRin_Valid    <= 1'b0;
            WRin_RegWr    <= 1'b0;
            WRin_MemtoReg <= 1'b0;
            WRin_Overflow <= 1'b0;
            WRin_AddrExc  <= 1'b0;
            WRin_BusErr   <= 1'b0;
            WRin_Dout     <= '0;
            WRin_ALUout   <= '0;
            WRin_Rw       <= '0;
        end else if (w_stall) begin
            WRin_Valid <= 1'b0;
            WRin_RegWr <= 1'b0;
        end else begin
            WRin_Valid    <= MEMin_Valid;
            WRin_RegWr    <= MEMin_RegWr & MEMin_Valid & ~w_misaligned & ~r_buserr;
            WRin_MemtoReg <= MEMin_MemtoReg;
            WRin_Overflow <= MEMin_Overflow;
            WRin_AddrExc  <= w_misaligned;
            WRin_BusErr   <= r_buserr;
            WRin_Dout     <= r_load_data;
            WRin_ALUout   <= DATA_W'(MEMin_ALUout);
            WRin_Rw       <= MEMin_Rw;
        end
    end

    // ------------------------------------------------------------------
    // Control transfer: only fires in the non-stalled cycle, so once per
    // instruction.
    // ------------------------------------------------------------------
    assign PCSrc          = MEMin_Valid & ~w_stall &
                            (MEMin_Jump | (MEMin_Branch & MEMin_Zero));
    assign Btarg_or_Jtarg = MEMin_Jump ? MEMin_Jtarg : MEMin_Btarg;

endmodule
`default_nettype wire

// File: tb/tb_stage_mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stage_mem_lsu
//  Purpose  : Self-checking bench for stage_mem_lsu (32-bit, timeout 4).
//             Directed scenarios followed by randomized accesses checked
//             against an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_stage_mem_lsu;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int RW = 5;
    localparam int TO = 4;

    logic          Clk = 1'b0;
    logic          Rst_n = 1'b0;
    logic          MEMin_Valid, MEMin_RegWr, MEMin_MemtoReg, MEMin_MemRd, MEMin_MemWr;
    logic          MEMin_Branch, MEMin_Jump, MEMin_Zero, MEMin_Overflow, MEMin_SignExt;
    logic [AW-1:0] MEMin_ALUout, MEMin_Btarg, MEMin_Jtarg;
    logic [DW-1:0] MEMin_busB, WR_RegDin, Mem_RData;
    logic [RW-1:0] MEMin_Rt, MEMin_Rw, WR_Rw;
    logic [1:0]    MEMin_Size;
    logic          WR_RegWr, Mem_Ack;
    logic          Mem_Req, Mem_We, Stall, PCSrc;
    logic [AW-1:0] Mem_Addr, Btarg_or_Jtarg;
    logic [DW-1:0] Mem_WData, WRin_Dout, WRin_ALUout;
    logic [3:0]    Mem_BE;
    logic          WRin_Valid, WRin_RegWr, WRin_MemtoReg, WRin_Overflow, WRin_AddrExc, WRin_BusErr;
    logic [RW-1:0] WRin_Rw;

    int n_cmp = 0;
    int n_err = 0;

    stage_mem_lsu #(.DATA_W(DW), .ADDR_W(AW), .REG_AW(RW), .MEM_TIMEOUT(TO)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .MEMin_Valid(MEMin_Valid), .MEMin_ALUout(MEMin_ALUout), .MEMin_busB(MEMin_busB),
        .MEMin_Rt(MEMin_Rt), .MEMin_Rw(MEMin_Rw), .MEMin_RegWr(MEMin_RegWr),
        .MEMin_MemtoReg(MEMin_MemtoReg), .MEMin_MemRd(MEMin_MemRd), .MEMin_MemWr(MEMin_MemWr),
        .MEMin_Branch(MEMin_Branch), .MEMin_Jump(MEMin_Jump), .MEMin_Zero(MEMin_Zero),
        .MEMin_Overflow(MEMin_Overflow), .MEMin_Size(MEMin_Size), .MEMin_SignExt(MEMin_SignExt),
        .MEMin_Btarg(MEMin_Btarg), .MEMin_Jtarg(MEMin_Jtarg),
        .WR_RegDin(WR_RegDin), .WR_Rw(WR_Rw), .WR_RegWr(WR_RegWr),
        .Mem_Req(Mem_Req), .Mem_We(Mem_We), .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData),
        .Mem_BE(Mem_BE), .Mem_Ack(Mem_Ack), .Mem_RData(Mem_RData),
        .Stall(Stall), .PCSrc(PCSrc), .Btarg_or_Jtarg(Btarg_or_Jtarg),
        .WRin_Valid(WRin_Valid), .WRin_RegWr(WRin_RegWr), .WRin_MemtoReg(WRin_MemtoReg),
        .WRin_Overflow(WRin_Overflow), .WRin_AddrExc(WRin_AddrExc), .WRin_BusErr(WRin_BusErr),
        .WRin_Dout(WRin_Dout), .WRin_ALUout(WRin_ALUout), .WRin_Rw(WRin_Rw)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout need completion");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Reference model: plain arithmetic on byte counts and offsets
    // ------------------------------------------------------------------
    function automatic bit model_misaligned(logic [31:0] addr, int size);
        int nb = 1 << size;
        return (size == 3) || ((addr % nb) != 0);
    endfunction

    function automatic logic [3:0] model_be(logic [31:0] addr, int size);
        int nb = 1 << size;
        int v  = ((1 << nb) - 1) << (addr % 4);
        return v[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(logic [31:0] src, int size);
        int nb = 1 << size;
        logic [31:0] r = 0;
        for (int b = 0; b < 4; b++) r = r | (((src >> (8 * (b % nb))) & 32'hFF) << (8 * b));
        return r;
    endfunction

    function automatic logic [31:0] model_load(logic [31:0] rdata, logic [31:0] addr, int size, bit sext);
        int nb = 1 << size;
        longint unsigned v = 64'(rdata);
        longint unsigned mask = (64'd1 << (8 * nb)) - 1;
        v = (v >> (8 * (addr % 4))) & mask;
        if (sext && (((v >> (8 * nb - 1)) & 1) == 1)) v = v | ~mask;
        return v[31:0];
    endfunction

    // ------------------------------------------------------------------
    // Stimulus helpers (no checking)
    // ------------------------------------------------------------------
    task automatic clear_instr();
        MEMin_Valid = 0; MEMin_RegWr = 0; MEMin_MemtoReg = 0; MEMin_MemRd = 0; MEMin_MemWr = 0;
        MEMin_Branch = 0; MEMin_Jump = 0; MEMin_Zero = 0; MEMin_Overflow = 0; MEMin_SignExt = 0;
        MEMin_ALUout = 0; MEMin_Btarg = 0; MEMin_Jtarg = 0; MEMin_busB = 0; MEMin_Rt = 0;
        MEMin_Rw = 0; MEMin_Size = 0; WR_RegDin = 0; WR_Rw = 0; WR_RegWr = 0; Mem_Ack = 0;
    endtask

    // Called right at a negedge with the instruction already driven. Plays the
    // memory (ack in the ack_lat-th request cycle; 0 = never), runs until the
    // first non-stalled cycle, then returns #1 after the following negedge
    // with the instruction withdrawn so MEM/WR can be inspected.
    task automatic run_access(input int ack_lat, output int stall_c, output int req_c,
                              output int pc_c, output logic [31:0] pc_t,
                              output logic [31:0] a_addr, output logic a_we,
                              output logic [3:0] a_be, output logic [31:0] a_wd,
                              output logic stable, output logic hung);
        int  widx = 0;
        logic seen = 0;
        stall_c = 0; req_c = 0; pc_c = 0; pc_t = 0; a_addr = 0; a_we = 0; a_be = 0;
        a_wd = 0; stable = 1; hung = 1;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (PCSrc) begin pc_c++; pc_t = Btarg_or_Jtarg; end
            if (Mem_Req) begin
                req_c++;
                if (!seen) begin
                    seen = 1; a_addr = Mem_Addr; a_we = Mem_We; a_be = Mem_BE; a_wd = Mem_WData;
                end else if (Mem_Addr !== a_addr || Mem_We !== a_we || Mem_BE !== a_be || Mem_WData !== a_wd) begin
                    stable = 0;
                end
            end
            if (!Stall) begin hung = 0; break; end
            stall_c++;
            if (Mem_Req) widx++;
            Mem_Ack = Mem_Req && (widx == ack_lat);
            @(negedge Clk);
        end
        Mem_Ack = 0;
        @(negedge Clk);
        MEMin_Valid = 0;
        #1;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        clear_instr();
        Mem_RData = 0;
        Rst_n = 0;
        repeat (3) @(negedge Clk);
        #1;
        n_cmp++; if ({Mem_Req, Mem_We, Mem_Addr, Mem_WData, Mem_BE} !== '0) begin n_err++;
            $display("FAIL reset_mem: got req=%b we=%b addr=%h wd=%h be=%h need all 0", Mem_Req, Mem_We, Mem_Addr, Mem_WData, Mem_BE); end
        n_cmp++; if ({WRin_Valid, WRin_RegWr, WRin_MemtoReg, WRin_Overflow, WRin_AddrExc, WRin_BusErr, WRin_Dout, WRin_ALUout, WRin_Rw} !== '0) begin n_err++;
            $display("FAIL reset_wrin: got v=%b rw=%b dout=%h alu=%h rd=%0d need all 0", WRin_Valid, WRin_RegWr, WRin_Dout, WRin_ALUout, WRin_Rw); end
        n_cmp++; if (Stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b need 0", Stall); end
        Rst_n = 1;
    endtask

    task automatic test_load_word();
        int s, r, pc; logic [31:0] pt, aa, wd; logic we, st, hg; logic [3:0] be;
        @(negedge Clk);
        clear_instr();
        MEMin_Valid = 1; MEMin_ALUout = 32'h100; MEMin_MemRd = 1; MEMin_Size = 2;
        MEMin_RegWr = 1; MEMin_MemtoReg = 1; MEMin_Rw = 7; Mem_RData = 32'hDEADBEEF;
        run_access(3, s, r, pc, pt, aa, we, be, wd, st, hg);
        n_cmp++; if (hg !== 0) begin n_err++; $display("FAIL lw_hang: got hung need completion"); end
        n_cmp++; if (s !== 4) begin n_err++; $display("FAIL lw_stall_cycles: got %0d need 4", s); end
        n_cmp++; if (be !== 4'hF || aa !== 32'h100 || we !== 0) begin n_err++;
            $display("FAIL lw_request: got be=%h addr=%h we=%b need be=f addr=100 we=0", be, aa, we); end
        n_cmp++; if (WRin_Dout !== 32'hDEADBEEF) begin n_err++; $display("FAIL lw_dout: got %h need deadbeef", WRin_Dout); end
        n_cmp++; if ({WRin_Valid, WRin_RegWr, WRin_MemtoReg, WRin_BusErr, WRin_AddrExc} !== 5'b11100) begin n_err++;
            $display("FAIL lw_flags: got %b need 11100", {WRin_Valid, WRin_RegWr, WRin_MemtoReg, WRin_BusErr, WRin_AddrExc}); end
        n_cmp++; if (WRin_Rw !== 5'd7 || WRin_ALUout !== 32'h100) begin n_err++;
            $display("FAIL lw_pass: got rw=%0d alu=%h need 7 100", WRin_Rw, WRin_ALUout); end
    endtask

    task automatic test_store_byte();
        int s, r, pc; logic [31:0] pt, aa, wd; logic we, st, hg; logic [3:0] be;
        logic [31:0] exp_wd [3] = '{32'hA5A5A5A5, 32'h3C3C3C3C, 32'hA5A5A5A5};
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            clear_instr();
            MEMin_Valid = 1; MEMin_ALUout = 32'h203; MEMin_MemWr = 1; MEMin_Size = 0;
            MEMin_busB = 32'h000000A5; MEMin_Rt = (k == 2) ? 5'd0 : 5'd3;
            WR_RegDin = 32'h3C; WR_Rw = MEMin_Rt; WR_RegWr = (k != 0);
            run_access(1, s, r, pc, pt, aa, we, be, wd, st, hg);
            n_cmp++; if (we !== 1 || be !== 4'h8 || aa !== 32'h200) begin n_err++;
                $display("FAIL sb%0d_request: got we=%b be=%h addr=%h need 1 8 200", k, we, be, aa); end
            n_cmp++; if (wd !== exp_wd[k]) begin n_err++;
                $display("FAIL sb%0d_wdata: got %h need %h", k, wd, exp_wd[k]); end
        end
    endtask

    task automatic test_signed_half();
        int s, r, pc; logic [31:0] pt, aa, wd; logic we, st, hg; logic [3:0] be;
        logic [31:0] exp_d [2] = '{32'hFFFF8001, 32'h00008001};
        for (int k = 0; k < 2; k++) begin
            @(negedge Clk);
            clear_instr();
            MEMin_Valid = 1; MEMin_ALUout = 32'h002; MEMin_MemRd = 1; MEMin_Size = 1;
            MEMin_SignExt = (k == 0); MEMin_RegWr = 1; Mem_RData = 32'h8001_1234;
            run_access(2, s, r, pc, pt, aa, we, be, wd, st, hg);
            n_cmp++; if (WRin_Dout !== exp_d[k]) begin n_err++;
                $display("FAIL lh%0d_dout: got %h need %h", k, WRin_Dout, exp_d[k]); end
            n_cmp++; if (be !== 4'hC) begin n_err++; $display("FAIL lh%0d_be: got %h need c", k, be); end
        end
    endtask

    task automatic test_misaligned();
        int s, r, pc; logic [31:0] pt, aa, wd; logic we, st, hg; logic [3:0] be;
        @(negedge Clk);
        clear_instr();
        MEMin_Valid = 1; MEMin_ALUout = 32'h101; MEMin_MemRd = 1; MEMin_Size = 2; MEMin_RegWr = 1;
        run_access(3, s, r, pc, pt, aa, we, be, wd, st, hg);
        n_cmp++; if (s !== 0 || r !== 0) begin n_err++; $display("FAIL mis_noreq: got stall=%0d req=%0d need 0 0", s, r); end
        n_cmp++; if (WRin_AddrExc !== 1 || WRin_RegWr !== 0 || WRin_Valid !== 1) begin n_err++;
            $display("FAIL mis_flags: got exc=%b regwr=%b valid=%b need 1 0 1", WRin_AddrExc, WRin_RegWr, WRin_Valid); end
    endtask

    task automatic test_timeout();
        int s, r, pc; logic [31:0] pt, aa, wd; logic we, st, hg; logic [3:0] be;
        for (int k = 0; k < 2; k++) begin
            // k=0: never acked; k=1: ack lands in the expiry cycle and wins
            @(negedge Clk);
            clear_instr();
            MEMin_Valid = 1; MEMin_ALUout = 32'h300; MEMin_MemRd = 1; MEMin_Size = 2;
            MEMin_RegWr = 1; Mem_RData = 32'h5A5A_1234;
            run_access((k == 0) ? 0 : TO, s, r, pc, pt, aa, we, be, wd, st, hg);
            n_cmp++; if (r !== TO || s !== TO + 1) begin n_err++;
                $display("FAIL to%0d_cycles: got req=%0d stall=%0d need %0d %0d", k, r, s, TO, TO + 1); end
            n_cmp++; if (WRin_BusErr !== (k == 0) || WRin_RegWr !== (k == 1)) begin n_err++;
                $display("FAIL to%0d_flags: got buserr=%b regwr=%b", k, WRin_BusErr, WRin_RegWr); end
            n_cmp++; if (WRin_Dout !== ((k == 0) ? 32'h0 : 32'h5A5A_1234)) begin n_err++;
                $display("FAIL to%0d_dout: got %h", k, WRin_Dout); end
        end
    endtask

    task automatic test_reset_mid_wait();
        int s, r, pc; logic [31:0] pt, aa, wd; logic we, st, hg; logic [3:0] be;
        @(negedge Clk);
        clear_instr();
        MEMin_Valid = 1; MEMin_ALUout = 32'h44; MEMin_MemRd = 1; MEMin_Size = 2;
        MEMin_RegWr = 1; MEMin_Rw = 9; Mem_RData = 32'h1122_3344;
        run_access(1, s, r, pc, pt, aa, we, be, wd, st, hg);
        @(negedge Clk);
        MEMin_Valid = 1;
        @(negedge Clk);
        #1;
        n_cmp++; if (Mem_Req !== 1) begin n_err++; $display("FAIL rstw_pre: got req=%b need 1", Mem_Req); end
        Rst_n = 0;
        @(negedge Clk);
        #1;
        n_cmp++; if (Mem_Req !== 0 || Mem_Addr !== 0 || Mem_BE !== 0) begin n_err++;
            $display("FAIL rstw_mem: got req=%b addr=%h be=%h need 0", Mem_Req, Mem_Addr, Mem_BE); end
        n_cmp++; if ({WRin_Valid, WRin_RegWr, WRin_MemtoReg, WRin_Overflow, WRin_AddrExc, WRin_BusErr, WRin_Dout, WRin_ALUout, WRin_Rw} !== '0) begin n_err++;
            $display("FAIL rstw_wrin: got dout=%h alu=%h rw=%0d need 0", WRin_Dout, WRin_ALUout, WRin_Rw); end
        MEMin_Valid = 0;
        Rst_n = 1;
    endtask

    task automatic test_branch_behind_load();
        int s, r, pc; logic [31:0] pt, aa, wd; logic we, st, hg; logic [3:0] be;
        @(negedge Clk);
        clear_instr();
        MEMin_Valid = 1; MEMin_ALUout = 32'h80; MEMin_MemRd = 1; MEMin_Size = 2;
        MEMin_Branch = 1; MEMin_Zero = 1; MEMin_Btarg = 32'h4000; MEMin_Jtarg = 32'h8000;
        run_access(2, s, r, pc, pt, aa, we, be, wd, st, hg);
        n_cmp++; if (pc !== 1 || pt !== 32'h4000) begin n_err++;
            $display("FAIL br_pcsrc: got pulses=%0d tgt=%h need 1 4000", pc, pt); end
        n_cmp++; if (PCSrc !== 0) begin n_err++; $display("FAIL br_after: got %b need 0", PCSrc); end
    endtask

    task automatic test_random();
        int s, r, pc; logic [31:0] pt, aa, wd; logic we, st, hg; logic [3:0] be;
        int kind, size, lat, exp_s, exp_pc;
        logic [31:0] addr, src, exp_d;
        bit mis, launched, berr;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            clear_instr();
            kind = $urandom_range(0, 2);
            size = (kind == 0) ? 0 : $urandom_range(0, 3);
            addr = $urandom;
            if ($urandom_range(0, 1) == 1) addr = addr & ~32'h3;
            lat = $urandom_range(1, TO + 1);
            MEMin_Valid = 1; MEMin_ALUout = addr; MEMin_Size = size[1:0];
            MEMin_MemRd = (kind == 1); MEMin_MemWr = (kind == 2);
            MEMin_SignExt = $urandom_range(0, 1); MEMin_RegWr = $urandom_range(0, 1);
            MEMin_MemtoReg = $urandom_range(0, 1); MEMin_Overflow = $urandom_range(0, 1);
            MEMin_Rw = $urandom; MEMin_busB = $urandom;
            MEMin_Rt = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            WR_RegDin = $urandom; WR_RegWr = $urandom_range(0, 1);
            WR_Rw = ($urandom_range(0, 1) == 1) ? MEMin_Rt : 5'($urandom);
            MEMin_Branch = $urandom_range(0, 1); MEMin_Jump = $urandom_range(0, 1); MEMin_Zero = $urandom_range(0, 1);
            MEMin_Btarg = $urandom; MEMin_Jtarg = $urandom; Mem_RData = $urandom;

            src = (WR_RegWr && WR_Rw == MEMin_Rt && MEMin_Rt != 0) ? WR_RegDin : MEMin_busB;
            mis = (kind != 0) && model_misaligned(addr, size);
            launched = (kind != 0) && !mis;
            berr = launched && (lat > TO);
            exp_s = !launched ? 0 : (berr ? TO + 1 : lat + 1);
            exp_pc = MEMin_Jump | (MEMin_Branch & MEMin_Zero);
            exp_d = berr ? 32'h0 : model_load(Mem_RData, addr, size, MEMin_SignExt);
            // capture before run_access withdraws the instruction
            begin
                logic [31:0] tgt; logic rwr, mtr, ovf; logic [4:0] rd;
                tgt = MEMin_Jump ? MEMin_Jtarg : MEMin_Btarg;
                rwr = MEMin_RegWr; mtr = MEMin_MemtoReg; ovf = MEMin_Overflow; rd = MEMin_Rw;
                run_access(lat, s, r, pc, pt, aa, we, be, wd, st, hg);
                n_cmp++; if (hg !== 0 || s !== exp_s) begin n_err++;
                    $display("FAIL rnd%0d_stall: got %0d (hung=%b) need %0d", i, s, hg, exp_s); end
                n_cmp++; if (pc !== exp_pc || (exp_pc == 1 && pt !== tgt)) begin n_err++;
                    $display("FAIL rnd%0d_pcsrc: got n=%0d tgt=%h need n=%0d tgt=%h", i, pc, pt, exp_pc, tgt); end
                n_cmp++; if ({WRin_Valid, WRin_RegWr, WRin_AddrExc, WRin_BusErr, WRin_MemtoReg, WRin_Overflow} !==
                             {1'b1, rwr & !mis & !berr, mis, berr, mtr, ovf}) begin n_err++;
                    $display("FAIL rnd%0d_flags: got %b need %b", i,
                             {WRin_Valid, WRin_RegWr, WRin_AddrExc, WRin_BusErr, WRin_MemtoReg, WRin_Overflow},
                             {1'b1, rwr & !mis & !berr, mis, berr, mtr, ovf}); end
                n_cmp++; if (WRin_Rw !== rd || WRin_ALUout !== addr) begin n_err++;
                    $display("FAIL rnd%0d_pass: got rw=%0d alu=%h need %0d %h", i, WRin_Rw, WRin_ALUout, rd, addr); end
                if (launched) begin
                    n_cmp++; if (aa !== (addr & ~32'h3) || be !== model_be(addr, size) || we !== (kind == 2) || st !== 1) begin n_err++;
                        $display("FAIL rnd%0d_req: got addr=%h be=%h we=%b stable=%b need %h %h %b 1", i, aa, be, we, st,
                                 addr & ~32'h3, model_be(addr, size), kind == 2); end
                end
                if (launched && kind == 2) begin
                    n_cmp++; if (wd !== model_wdata(src, size)) begin n_err++;
                        $display("FAIL rnd%0d_wdata: got %h need %h", i, wd, model_wdata(src, size)); end
                end
                if (launched && kind == 1) begin
                    n_cmp++; if (WRin_Dout !== exp_d) begin n_err++;
                        $display("FAIL rnd%0d_dout: got %h need %h", i, WRin_Dout, exp_d); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_store_byte();
        test_signed_half();
        test_misaligned();
        test_timeout();
        test_reset_mid_wait();
        test_branch_behind_load();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
